// File: rtl/dcache_req_arbiter_pkg.sv
// Shared types and constants for the HPDC request arbiter and its round-robin helper.
package dcache_req_arbiter_pkg;

    localparam int DCACHE_ARB_MAX_REQ = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_DRAIN = 2'd1,
        ARB_DONE  = 2'd2
    } dcache_arb_state_t;

    typedef enum logic {
        TAG_FREE    = 1'b0,
        TAG_PENDING = 1'b1
    } tag_state_t;

endpackage

// File: rtl/dcache_req_arbiter_rr.sv
// Round-robin arbiter: scans from the held pointer upward with wrap; the pointer
// moves past the winner only when the caller strobes advance_i.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N-1:0]     req_i,
    input  logic             advance_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] winIdx;
    logic             found;
    int               cand;

    always_comb begin
        winIdx = '0;
        found  = 1'b0;
        cand   = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr_q) + k) % N;
            if (!found && req_i[cand]) begin
                found  = 1'b1;
                winIdx = IDX_W'(cand);
            end
        end
    end

    assign idx_o   = winIdx;
    assign valid_o = found;
    assign grant_o = found ? (N'(1) << winIdx) : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && found) begin
            ptr_d = (int'(winIdx) == N - 1) ? '0 : winIdx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dcache_req_arbiter.sv
// Shares one HPDC port among NUM_REQ requesters: RR grant, tid pool, response routing, fence drain.
// Define DCACHE_ARB_CHECK_EN to enable the sticky protocol-error flag on error_o.
module dcache_req_arbiter
    import dcache_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int NUM_TAGS  = 16,
    parameter int TID_W     = 7,
    parameter int PAYLOAD_W = 128,
    parameter int DATA_W    = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*PAYLOAD_W-1:0]  req_payload_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          dc_req_valid_o,
    input  logic                          dc_req_ready_i,
    output logic [PAYLOAD_W-1:0]          dc_req_payload_o,
    output logic [TID_W-1:0]              dc_req_tid_o,
    input  logic                          dc_rsp_valid_i,
    input  logic [TID_W-1:0]              dc_rsp_tid_i,
    input  logic [DATA_W-1:0]             dc_rsp_data_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_W-1:0]             rsp_data_o,
    input  logic                          fence_req_i,
    input  logic                          wbuf_empty_i,
    output logic                          fence_done_o,
    output logic [$clog2(NUM_TAGS):0]     inflight_o,
    output logic                          error_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TAG_W = $clog2(NUM_TAGS);
    localparam int CNT_W = TAG_W + 1;

    tag_state_t        tagState_q [NUM_TAGS];
    logic [IDX_W-1:0]  owner_q    [NUM_TAGS];
    logic [CNT_W-1:0]  inflight_q;
    logic [CNT_W-1:0]  inflight_d;
    dcache_arb_state_t state_q;
    logic              fenceDone_q;

    logic [NUM_REQ-1:0] grantVec;
    logic [IDX_W-1:0]   grantIdx;
    logic               anyReq;
    logic               handshake;
    logic [TAG_W-1:0]   freeIdx;
    logic               freeExists;
    logic               rspInRange;
    logic [TAG_W-1:0]   rspIdx;
    logic               rspHit;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_valid_i),
        .advance_i (handshake),
        .grant_o   (grantVec),
        .idx_o     (grantIdx),
        .valid_o   (anyReq)
    );

    // Only tags FREE at the start of the cycle are candidates, so a tag released this cycle waits one cycle.
    always_comb begin
        freeIdx    = '0;
        freeExists = 1'b0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (tagState_q[i] == TAG_FREE) begin
                freeIdx    = TAG_W'(i);
                freeExists = 1'b1;
            end
        end
    end

    assign dc_req_valid_o   = anyReq && freeExists && (state_q == ARB_IDLE);
    assign handshake        = dc_req_valid_o && dc_req_ready_i;
    assign req_ready_o      = handshake ? grantVec : '0;
    assign dc_req_payload_o = req_payload_i[grantIdx*PAYLOAD_W +: PAYLOAD_W];
    assign dc_req_tid_o     = TID_W'(freeIdx);

    assign rspInRange  = ({1'b0, dc_rsp_tid_i} < (TID_W+1)'(NUM_TAGS));
    assign rspIdx      = dc_rsp_tid_i[TAG_W-1:0];
    assign rspHit      = dc_rsp_valid_i && rspInRange && (tagState_q[rspIdx] == TAG_PENDING);
    assign rsp_valid_o = rspHit ? (NUM_REQ'(1) << owner_q[rspIdx]) : '0;
    assign rsp_data_o  = rspHit ? dc_rsp_data_i : '0;

    assign inflight_d = inflight_q + CNT_W'(handshake) - CNT_W'(rspHit);
    assign inflight_o = inflight_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                tagState_q[i] <= TAG_FREE;
                owner_q[i]    <= '0;
            end
            inflight_q <= '0;
        end else begin
            if (handshake) begin
                tagState_q[freeIdx] <= TAG_PENDING;
                owner_q[freeIdx]    <= grantIdx;
            end
            if (rspHit) begin
                tagState_q[rspIdx] <= TAG_FREE;
            end
            inflight_q <= inflight_d;
        end
    end

    // Fence sequencing; dropping the fence while draining abandons it without signalling done.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ARB_IDLE;
            fenceDone_q <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    fenceDone_q <= 1'b0;
                    if (fence_req_i) state_q <= ARB_DRAIN;
                end
                ARB_DRAIN: begin
                    if (!fence_req_i) begin
                        state_q <= ARB_IDLE;
                    end else if (inflight_q == '0 && wbuf_empty_i) begin
                        state_q     <= ARB_DONE;
                        fenceDone_q <= 1'b1;
                    end
                end
                ARB_DONE: begin
                    if (!fence_req_i) begin
                        state_q     <= ARB_IDLE;
                        fenceDone_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ARB_IDLE;
                    fenceDone_q <= 1'b0;
                end
            endcase
        end
    end

    assign fence_done_o = fenceDone_q;

`ifdef DCACHE_ARB_CHECK_EN
    logic errEvent;
    logic error_q;

    assign errEvent = dc_rsp_valid_i && (!rspInRange || (tagState_q[rspIdx] == TAG_FREE));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            error_q <= 1'b0;
        end else if (errEvent) begin
            error_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i && errEvent) begin
            $error("dcache_req_arbiter: response to unallocated tid %0d at %0t", dc_rsp_tid_i, $time);
        end
    end
`endif

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: doc/dcache_req_arbiter.md
Name: dcache_req_arbiter

Overview:
- Shares the single HPDC request/response port between NUM_REQ core requesters (LSU, PTW, vector unit).
- Round-robin arbitration on the request side.
- Allocates the HPDC transaction tag (tid) from a free pool, so requesters never see tag collisions.
- Routes each response back to its originating requester by tid.
- Provides a fence/drain sequence that blocks new requests until all in-flight transactions complete and the write buffer is empty.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- NUM_TAGS, 16, size of the tid pool (power of two, 2..128).
- TID_W, 7, width of the HPDC tid field (NUM_TAGS <= 2**TID_W).
- PAYLOAD_W, 128, opaque request payload width (op/addr/be/wdata/size), passed through unchanged.
- DATA_W, 64, response data width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_payload_i  in  NUM_REQ*PAYLOAD_W  per-requester payload.
- req_ready_o  out  NUM_REQ  per-requester accept.
- dc_req_valid_o  out  1  request valid to HPDC.
- dc_req_ready_i  in  1  HPDC ready.
- dc_req_payload_o  out  PAYLOAD_W  granted payload.
- dc_req_tid_o  out  TID_W  allocated tid.
- dc_rsp_valid_i  in  1  HPDC response valid.
- dc_rsp_tid_i  in  TID_W  response tid.
- dc_rsp_data_i  in  DATA_W  response data.
- rsp_valid_o  out  NUM_REQ  one-hot response valid to the owning requester.
- rsp_data_o  out  DATA_W  response data, shared by all requesters.
- fence_req_i  in  1  drain request (level, held until done).
- wbuf_empty_i  in  1  HPDC write buffer empty.
- fence_done_o  out  1  drain complete.
- inflight_o  out  $clog2(NUM_TAGS)+1  outstanding transaction count.
- error_o  out  1  protocol error flag (see Optional Feature).

Behaviour:
- Reset (rst_i high at a clock edge):
  - All tags FREE, owner table cleared, RR pointer 0, inflight 0, FSM IDLE.
  - All outputs 0, except dc_req_payload_o/dc_req_tid_o, which are don't-care with valid low.
- Grant is combinational, same cycle:
  - Candidate = first requester with req_valid_i set, scanning from the RR pointer upward with wrap.
  - dc_req_valid_o = any req_valid_i AND free tag exists AND FSM==IDLE.
  - req_ready_o[g] = dc_req_valid_o AND dc_req_ready_i, for the granted index g only.
- Handshake (dc_req_valid_o & dc_req_ready_i):
  - Allocate the lowest-index FREE tag; it drives dc_req_tid_o that cycle.
  - Next edge: tag becomes PENDING, owner[tag] = g, RR pointer = (g+1) mod NUM_REQ.
  - RR pointer does not move without a handshake.
- Payload is passed unmodified. The grant must not change while dc_req_valid_o is high and dc_req_ready_i is low, as long as the requester holds valid.
- Response (dc_rsp_valid_i with PENDING tid):
  - rsp_valid_o[owner[tid]] asserted the same cycle; rsp_data_o = dc_rsp_data_i.
  - Tag returns to FREE at the next edge.
- Response to a FREE tid: dropped, no rsp_valid_o.
- Simultaneous alloc and free: a tag freed in cycle N is not allocatable before cycle N+1. inflight updates as +send-receive, so it is unchanged when both occur.
- Pool exhausted (inflight == NUM_TAGS): dc_req_valid_o=0 and all req_ready_o=0. The request resumes the cycle after a response frees a tag.
- Fence FSM:
  - IDLE -> DRAIN on fence_req_i.
  - DRAIN: no new grants. DRAIN -> DONE when inflight==0 && wbuf_empty_i.
  - DONE: fence_done_o=1 (registered). DONE -> IDLE when fence_req_i drops.
  - If fence_req_i drops while in DRAIN: return to IDLE, no fence_done_o.
  - Responses continue to be routed in all states.
- Reset mid-operation: all tags freed. Late responses for pre-reset tids are dropped per the FREE rule.

Optional Feature:
- Macro: DCACHE_ARB_CHECK_EN.
- Defined:
  - error_o becomes a sticky flag, set the cycle after a response to a FREE tid, or after dc_rsp_tid_i >= NUM_TAGS.
  - Cleared only by reset.
  - In simulation, also issues $error with the tid and $time.
- Undefined: error_o tied 0; no check logic is synthesized.

Decomposition:
- drac_pkg additions:
  - dcache_arb_state_t enum {ARB_IDLE, ARB_DRAIN, ARB_DONE}.
  - tag_state_t enum {TAG_FREE, TAG_PENDING}.
  - Constant DCACHE_ARB_MAX_REQ=8.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req vector, advance strobe.
  - Outputs: one-hot grant and index.
  - Holds the RR pointer.
  - Reused elsewhere in the core.
- Tag pool, owner table, counter and FSM stay in dcache_req_arbiter.

Test Plan:
- All 3 requesters valid continuously, dc_req_ready_i=1 -> grants 0,1,2,0,1,2; tids 0,1,2,3,4,5; inflight reaches 6.
- 16 requests issued with no responses -> dc_req_valid_o=0 on the 17th. Respond tid 5 -> rsp_valid_o to tid 5's owner; next cycle tid 5 is reallocated.
- Response tid 3 and a new grant in the same cycle -> new tid is the lowest free excluding 3; inflight unchanged.
- 4 in flight, wbuf_empty_i=0, raise fence_req_i -> no grants. Return all 4 responses, then wbuf_empty_i=1 -> fence_done_o=1 the next cycle. Drop fence -> IDLE, grants resume.
- Assert rst_i with 5 in flight, then send a response for tid 2 -> no rsp_valid_o; error_o=1 only with DCACHE_ARB_CHECK_EN defined.
- Hold dc_req_ready_i=0 for 3 cycles with requesters 1 and 2 valid -> grant stays on 1, RR pointer unchanged, payload stable.
